// File: rtl/cpu20_pkg.sv
// rtl/cpu20_pkg.sv - shared widths, sequencer state encoding and register-file direction constants
// Purpose: common definitions for the operand-fetch / writeback sequencer.
// Contents: DATA_W, ADDR_W, state_e, RF_READ / RF_WRITE.
package cpu20_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_B    = 3'd2,
    CAP_B   = 3'd3,
    OPV     = 3'd4,
    WB_WAIT = 3'd5,
    WR      = 3'd6
  } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - request, operand, writeback and register-file signals of the sequencer
// Purpose: bundles every non-clock/reset signal of regfile_sequencer.
// Ports (sequencer view, slave modport):
//   request   : i_req_valid, o_req_ready, i_rs1, i_rs2, i_rd, i_rd_en
//   operands  : o_op_valid, i_op_ready, o_op_a, o_op_b
//   writeback : i_wb_valid, o_wb_ready, i_wb_data
//   reg file  : o_rf_addr, o_rf_rw, o_rf_wdata, i_rf_rdata
//   status    : o_busy
interface regfile_sequencer_if #(
  parameter int DATA_W = cpu20_pkg::DATA_W,
  parameter int ADDR_W = cpu20_pkg::ADDR_W
);

  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_rs1;
  logic [ADDR_W-1:0] i_rs2;
  logic [ADDR_W-1:0] i_rd;
  logic              i_rd_en;

  logic              o_op_valid;
  logic              i_op_ready;
  logic [DATA_W-1:0] o_op_a;
  logic [DATA_W-1:0] o_op_b;

  logic              i_wb_valid;
  logic              o_wb_ready;
  logic [DATA_W-1:0] i_wb_data;

  logic [ADDR_W-1:0] o_rf_addr;
  logic              o_rf_rw;
  logic [DATA_W-1:0] o_rf_wdata;
  logic [DATA_W-1:0] i_rf_rdata;

  logic              o_busy;

  // The sequencer itself
  modport slave (
    input  i_req_valid, i_rs1, i_rs2, i_rd, i_rd_en,
    input  i_op_ready, i_wb_valid, i_wb_data, i_rf_rdata,
    output o_req_ready, o_op_valid, o_op_a, o_op_b,
    output o_wb_ready, o_rf_addr, o_rf_rw, o_rf_wdata, o_busy
  );

  // The requester / register-file environment around it
  modport master (
    output i_req_valid, i_rs1, i_rs2, i_rd, i_rd_en,
    output i_op_ready, i_wb_valid, i_wb_data, i_rf_rdata,
    input  o_req_ready, o_op_valid, o_op_a, o_op_b,
    input  o_wb_ready, o_rf_addr, o_rf_rw, o_rf_wdata, o_busy
  );

endinterface

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - operand fetch and writeback sequencer for a 1-cycle registered-read register file
// Purpose: accepts a (rs1, rs2, rd, rd_en) request, reads rs1 then rs2, presents both
//   operands, and optionally waits for a writeback result to store into rd.
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : regfile_sequencer_if.slave (request, operand, writeback, reg-file, busy)
module regfile_sequencer #(
  parameter int DATA_W = cpu20_pkg::DATA_W,
  parameter int ADDR_W = cpu20_pkg::ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  regfile_sequencer_if.slave    bus
);

  import cpu20_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              req_ready;
  logic              op_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_rw;
  logic [DATA_W-1:0] rf_wdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rd_en_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rd_en_q   <= rd_en_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rd_en_d   = rd_en_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    wb_data_d = wb_data_q;

    req_ready = 1'b0;
    op_valid  = 1'b0;
    wb_ready  = 1'b0;
    rf_addr   = '0;
    rf_rw     = RF_READ;
    rf_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.i_req_valid) begin
          rs1_d   = bus.i_rs1;
          rs2_d   = bus.i_rs2;
          rd_d    = bus.i_rd;
          rd_en_d = bus.i_rd_en;
          state_d = RD_A;
        end
      end
      RD_A: begin
        rf_addr = rs1_q;
        state_d = RD_B;
      end
      // Read data lags the address by one cycle, so rs1's data arrives while rs2 is driven
      RD_B: begin
        rf_addr = rs2_q;
        op_a_d  = bus.i_rf_rdata;
        state_d = CAP_B;
      end
      CAP_B: begin
        op_b_d  = bus.i_rf_rdata;
        state_d = OPV;
      end
      OPV: begin
        op_valid = 1'b1;
        if (bus.i_op_ready) begin
          state_d = rd_en_q ? WB_WAIT : IDLE;
        end
      end
      WB_WAIT: begin
        wb_ready = 1'b1;
        if (bus.i_wb_valid) begin
          wb_data_d = bus.i_wb_data;
          state_d   = WR;
        end
      end
      // The only state that writes; rd==rs1/rs2 therefore always sees old operands
      WR: begin
        rf_addr  = rd_q;
        rf_rw    = RF_WRITE;
        rf_wdata = wb_data_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_op_valid  = op_valid;
  assign bus.o_op_a      = op_a_q;
  assign bus.o_op_b      = op_b_q;
  assign bus.o_wb_ready  = wb_ready;
  assign bus.o_rf_addr   = rf_addr;
  assign bus.o_rf_rw     = rf_rw;
  assign bus.o_rf_wdata  = rf_wdata;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer with a registered-read register file model
module tb_regfile_sequencer;

  logic clk;
  logic rst_n;

  int tests = 0;
  int fails = 0;
  bit mon_en = 0;

  regfile_sequencer_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  regfile_sequencer #(.DATA_W(16), .ADDR_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: one-cycle registered read, write on o_rf_rw, plus a preload port
  logic [15:0] rf_mem [16];
  logic [15:0] rf_rdata_q;
  logic        pl_we;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) rf_mem[pl_addr] <= pl_data;
    else if (bus.o_rf_rw) rf_mem[bus.o_rf_addr] <= bus.o_rf_wdata;
    rf_rdata_q <= rf_mem[bus.o_rf_addr];
  end
  assign bus.i_rf_rdata = rf_rdata_q;

  // Reference model: architectural register contents
  logic [15:0] ref_mem [16];

  logic [31:0] exp_ops [$];
  logic [19:0] exp_wr  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected operands on each handshake and expected writes on each write cycle
  bit          hold_pending = 0;
  logic [15:0] held_a, held_b;
  logic [31:0] e_ops;
  logic [19:0] e_wr;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.o_op_valid) begin
        if (hold_pending) begin
          check("op_a_stable", {16'h0, bus.o_op_a}, {16'h0, held_a});
          check("op_b_stable", {16'h0, bus.o_op_b}, {16'h0, held_b});
        end
        if (bus.i_op_ready) begin
          hold_pending = 0;
          tests++;
          if (exp_ops.size() == 0) begin
            fails++;
            $display("FAIL op_unexpected: got a=0x%0h b=0x%0h expected no operands", bus.o_op_a, bus.o_op_b);
          end else begin
            tests--;
            e_ops = exp_ops.pop_front();
            check("op_a", {16'h0, bus.o_op_a}, {16'h0, e_ops[31:16]});
            check("op_b", {16'h0, bus.o_op_b}, {16'h0, e_ops[15:0]});
          end
        end else begin
          hold_pending = 1;
          held_a = bus.o_op_a;
          held_b = bus.o_op_b;
        end
      end else begin
        hold_pending = 0;
      end
      if (bus.o_rf_rw) begin
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got write addr=%0d data=0x%0h expected none", bus.o_rf_addr, bus.o_rf_wdata);
        end else begin
          tests--;
          e_wr = exp_wr.pop_front();
          check("wr_addr", {28'h0, bus.o_rf_addr}, {28'h0, e_wr[19:16]});
          check("wr_data", {16'h0, bus.o_rf_wdata}, {16'h0, e_wr[15:0]});
        end
      end
      if (!bus.o_busy) begin
        check("idle_ready", {31'h0, bus.o_req_ready}, 32'd1);
        check("idle_addr_wdata", {12'h0, bus.o_rf_addr, bus.o_rf_wdata}, 32'd0);
        check("idle_rw", {31'h0, bus.o_rf_rw}, 32'd0);
      end
    end
  end

  task automatic check_reset_state();
    check("rst_req_ready", {31'h0, bus.o_req_ready}, 32'd1);
    check("rst_busy", {31'h0, bus.o_busy}, 32'd0);
    check("rst_op_valid", {31'h0, bus.o_op_valid}, 32'd0);
    check("rst_wb_ready", {31'h0, bus.o_wb_ready}, 32'd0);
    check("rst_ops", {bus.o_op_a, bus.o_op_b}, 32'd0);
    check("rst_rf", {11'h0, bus.o_rf_rw, bus.o_rf_addr, bus.o_rf_wdata}, 32'd0);
  endtask

  task automatic noise();
    bus.i_req_valid = 1'($urandom_range(0, 1));
    bus.i_rs1       = 4'($urandom);
    bus.i_rs2       = 4'($urandom);
    bus.i_rd        = 4'($urandom);
    bus.i_rd_en     = 1'($urandom_range(0, 1));
    bus.i_wb_valid  = 1'($urandom_range(0, 1));
    bus.i_wb_data   = 16'($urandom);
  endtask

  task automatic do_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic rd_en, input int rdy_dly, input logic [15:0] wdata,
                        input int wb_dly, input bit abort, input bit b2b);
    int n;
    if (b2b) check("b2b_ready", {31'h0, bus.o_req_ready}, 32'd1);
    n = 0;
    while (!bus.o_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("req_ready_timeout", 32'd0, 32'd1);
    bus.i_req_valid = 1'b1;
    bus.i_rs1 = rs1;
    bus.i_rs2 = rs2;
    bus.i_rd = rd;
    bus.i_rd_en = rd_en;
    bus.i_op_ready = (rdy_dly == 0);
    exp_ops.push_back({ref_mem[rs1], ref_mem[rs2]});
    @(posedge clk); #1;
    noise();
    n = 0;
    while (!bus.o_op_valid && n < 10) begin
      @(posedge clk); #1; n++;
      noise();
    end
    check("op_latency", n, 32'd3);
    for (int k = 0; k < rdy_dly; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, bus.o_op_valid}, 32'd1);
      check("hold_req_ready", {31'h0, bus.o_req_ready}, 32'd0);
    end
    bus.i_req_valid = 1'b0;
    bus.i_wb_valid = 1'b0;
    bus.i_op_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_op_ready = 1'b0;
    if (rd_en) begin
      check("wb_ready", {31'h0, bus.o_wb_ready}, 32'd1);
      for (int k = 0; k < wb_dly; k++) begin
        @(posedge clk); #1;
      end
      bus.i_wb_valid = 1'b1;
      bus.i_wb_data = wdata;
      if (abort) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_wb_valid = 1'b0;
        check_reset_state();
      end else begin
        exp_wr.push_back({rd, wdata});
        ref_mem[rd] = wdata;
        @(posedge clk); #1;
        bus.i_wb_valid = 1'b0;
        check("wr_cycle_rw", {31'h0, bus.o_rf_rw}, 32'd1);
        @(posedge clk); #1;
        check("after_wr_ready", {31'h0, bus.o_req_ready}, 32'd1);
      end
    end else begin
      check("after_hs_ready", {31'h0, bus.o_req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b0;
    pl_we = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    bus.i_req_valid = 1'b0;
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    bus.i_rd = '0;
    bus.i_rd_en = 1'b0;
    bus.i_op_ready = 1'b0;
    bus.i_wb_valid = 1'b0;
    bus.i_wb_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      if (i == 3) v = 16'h1234;
      if (i == 7) v = 16'hBEEF;
      if (i == 2) v = 16'h00FF;
      ref_mem[i] = v;
      pl_we = 1'b1;
      pl_addr = 4'(i);
      pl_data = v;
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_state();
    mon_en = 1;

    do_req(4'd3, 4'd7, 4'd0, 1'b0, 0, 16'h0, 0, 0, 0);
    do_req(4'd2, 4'd2, 4'd2, 1'b1, 0, 16'hA5A5, 1, 0, 0);
    do_req(4'd2, 4'd3, 4'd0, 1'b0, 0, 16'h0, 0, 0, 0);
    check("r2_written", {16'h0, ref_mem[2]}, 32'h0000A5A5);
    do_req(4'd7, 4'd3, 4'd9, 1'b0, 5, 16'h0, 0, 0, 0);
    do_req(4'd4, 4'd5, 4'd4, 1'b1, 0, 16'hDEAD, 2, 1, 0);
    do_req(4'd4, 4'd4, 4'd0, 1'b0, 0, 16'h0, 0, 0, 0);
    do_req(4'd1, 4'd6, 4'd0, 1'b0, 0, 16'h0, 0, 0, 0);
    do_req(4'd6, 4'd1, 4'd0, 1'b0, 0, 16'h0, 0, 0, 1);

    bus.i_wb_valid = 1'b1;
    bus.i_wb_data = 16'h5555;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_wb_ignored", {30'h0, bus.o_busy, bus.o_rf_rw}, 32'd0);
    end
    bus.i_wb_valid = 1'b0;

    for (int t = 0; t < 30; t++) begin
      do_req(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 2)), 0,
             ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clk);
    #1;
    check("ops_drained", exp_ops.size(), 32'd0);
    check("wr_drained", exp_wr.size(), 32'd0);
    for (int i = 0; i < 16; i++) check("rf_final", {16'h0, rf_mem[i]}, {16'h0, ref_mem[i]});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, register data width; ADDR_W, 4, register address width (16 registers).
REQ-002 Port i_clk SHALL be input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port i_rst_n SHALL be input, 1 bit: reset, synchronous and active-low.
REQ-004 Port i_req_valid SHALL be input, 1 bit: an operand-fetch request is presented.
REQ-005 Port o_req_ready SHALL be output, 1 bit: the block can accept a request.
REQ-006 Ports i_rs1, i_rs2, i_rd SHALL each be input, ADDR_W bits: the source A, source B and destination register addresses.
REQ-007 Port i_rd_en SHALL be input, 1 bit: the request includes a writeback to i_rd.
REQ-008 Port o_op_valid SHALL be output, 1 bit: operands are valid. Port i_op_ready SHALL be input, 1 bit: the consumer accepts the operands.
REQ-009 Ports o_op_a and o_op_b SHALL each be output, DATA_W bits: the fetched contents of rs1 and rs2.
REQ-010 Port i_wb_valid SHALL be input, 1 bit; port o_wb_ready SHALL be output, 1 bit; port i_wb_data SHALL be input, DATA_W bits: the writeback result handshake.
REQ-011 Port o_rf_addr SHALL be output, ADDR_W bits, and port o_rf_rw SHALL be output, 1 bit (1=write, 0=read): the register-file address and direction.
REQ-012 Port o_rf_wdata SHALL be output, DATA_W bits: register-file write data. Port i_rf_rdata SHALL be input, DATA_W bits: register-file read data.
REQ-013 Port o_busy SHALL be output, 1 bit: high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_A, RD_B, CAP_B, OPV, WB_WAIT and WR.
REQ-015 o_req_ready SHALL be 1 only in IDLE; i_req_valid=1 in IDLE SHALL latch rs1, rs2, rd and rd_en and go to RD_A.
REQ-016 The register file SHALL be treated as having a 1-cycle registered read: rdata reflects the address driven in the previous cycle.
REQ-017 RD_A SHALL drive o_rf_addr=rs1 with rw=0, then go to RD_B.
REQ-018 RD_B SHALL drive o_rf_addr=rs2 with rw=0 and capture i_rf_rdata into o_op_a, then go to CAP_B.
REQ-019 CAP_B SHALL capture i_rf_rdata into o_op_b, then go to OPV.
REQ-020 o_op_valid SHALL rise exactly 3 cycles after the request-accept edge.
REQ-021 In OPV, o_op_valid=1 and o_op_a/o_op_b SHALL hold stable until i_op_ready=1.
REQ-022 On the OPV handshake the FSM SHALL go to WB_WAIT if rd_en=1, else to IDLE.
REQ-023 In WB_WAIT, o_wb_ready SHALL be 1; i_wb_valid=1 SHALL latch i_wb_data and go to WR.
REQ-024 WR SHALL drive o_rf_addr=rd, o_rf_rw=1 and o_rf_wdata=the latched data for exactly one cycle, then go to IDLE.
REQ-025 o_rf_rw SHALL be 0 in every state except WR.
REQ-026 In IDLE, o_rf_addr SHALL be 0 and o_rf_wdata SHALL be 0.
REQ-027 When rs1==rs2, two reads SHALL still be issued, with op_a==op_b.
REQ-028 When rd equals rs1 or rs2, the write SHALL occur only in WR, after both reads, so the operands reflect the old values.
REQ-029 i_wb_valid outside WB_WAIT and i_req_valid outside IDLE SHALL be ignored; no stored state is affected.
REQ-030 A request SHALL be accepted in the IDLE cycle immediately following WR, or following the OPV handshake when rd_en=0; there are no bubble cycles.

Reset
REQ-031 When i_rst_n=0 at a rising edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 in the next cycle, except o_req_ready=1.
REQ-032 Reset in any state, including WR, SHALL abort the transaction; any write not yet driven SHALL be discarded and o_rf_rw SHALL return to 0 on the next cycle.
REQ-033 The latched addresses, operands and writeback data SHALL reset to 0.

Structure
REQ-034 DATA_W, ADDR_W, the state enum typedef, and the RF_READ=0 / RF_WRITE=1 constants SHALL reside in the shared package cpu20_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the bench SHALL connect it to the existing register file model.

Verification
REQ-036 Preload r3=0x1234 and r7=0xBEEF; request rs1=3, rs2=7, rd_en=0 with i_op_ready=1 -> o_op_valid on cycle 3 with op_a=0x1234 and op_b=0xBEEF, then IDLE.
REQ-037 Request rs1=2, rs2=2, rd=2, rd_en=1 with r2=0x00FF, then wb_data=0xA5A5 -> op_a=op_b=0x00FF, one WR cycle with addr=2, rw=1; a later read of r2 returns 0xA5A5.
REQ-038 Hold i_op_ready=0 for 5 cycles -> o_op_valid stays 1, operands are stable and o_req_ready=0; the handshake then completes on cycle 6.
REQ-039 Assert reset in WB_WAIT after the OPV handshake -> next cycle is IDLE with all outputs 0 and o_req_ready=1; no write occurs and r[rd] is unchanged.
REQ-040 Issue back-to-back requests (rd_en=0, i_op_ready=1) -> the second request is accepted in the cycle after the first handshake; pulse i_wb_valid in IDLE -> no effect.
